// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// Detects a WIDTH-bit programmable pattern (MSB = first bit received) on a
// qualified serial stream, with overlapping or non-overlapping detection,
// a registered one-cycle match pulse and a saturating match counter.
// Optional feature: define SEQDET_MASK_EN to add a per-bit don't-care mask
// (pat_mask_in, loaded with pat_in; mask bit 1 = ignore that bit).
module seq_detector_param #(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [WIDTH-1:0] pat_mask_in,
`endif
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int unsigned FillW = $clog2(WIDTH + 1);
    localparam logic [FillW-1:0] FillMax  = FillW'(WIDTH);
    localparam logic [FillW-1:0] FillLast = FillW'(WIDTH - 1);

    typedef enum logic [0:0] {StFill, StArmed} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQDET_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
`endif

    logic [WIDTH-1:0] hist_n;
    logic             accept;
    logic             cmp_ok;
    logic             hit;

    // Candidate history and hit detection for the bit offered this cycle
    always_comb begin
        hist_n = {hist_q[WIDTH-2:0], in_bit};
        // A pattern load wins over the same-cycle bit, which is dropped
        accept = in_valid && !pat_load;
`ifdef SEQDET_MASK_EN
        cmp_ok = ((hist_n ^ pat_q) & ~mask_q) == '0;
`else
        cmp_ok = (hist_n == pat_q);
`endif
        hit = accept && (fill_q >= FillLast) && cmp_ok;
    end

    // Next-state logic for history, fill, pattern, match pulse and counter
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
`ifdef SEQDET_MASK_EN
        mask_d  = mask_q;
`endif

        if (pat_load) begin
            pat_d   = pat_in;
`ifdef SEQDET_MASK_EN
            mask_d  = pat_mask_in;
`endif
            fill_d  = '0;
            state_d = StFill;
        end else if (in_valid) begin
            hist_d  = hist_n;
            match_d = hit;
            if (hit && !overlap) begin
                // Non-overlapping: the next match needs WIDTH fresh bits
                fill_d  = '0;
                state_d = StFill;
            end else begin
                fill_d  = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
                state_d = (fill_d == FillMax) ? StArmed : StFill;
            end
        end

        if (cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            hist_q  <= '0;
            pat_q   <= PATTERN;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQDET_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
`ifdef SEQDET_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign armed       = (state_q == StArmed);

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (directed vectors).
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (for saturation).
// Define SEQDET_MASK_EN to also exercise the don't-care mask.
module tb_seq_detector_param;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             overlap;
    logic             pat_load;
    logic [WIDTH-1:0] pat_in;
    logic             cnt_clr;
`ifdef SEQDET_MASK_EN
    logic [WIDTH-1:0] pat_mask_in;
`endif
    logic             match, match2;
    logic [7:0]       match_count;
    logic [1:0]       match_count2;
    logic             armed, armed2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
`ifdef SEQDET_MASK_EN
        .pat_mask_in (pat_mask_in),
`endif
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .armed       (armed)
    );

    seq_detector_param #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
`ifdef SEQDET_MASK_EN
        .pat_mask_in (pat_mask_in),
`endif
        .cnt_clr     (cnt_clr),
        .match       (match2),
        .match_count (match_count2),
        .armed       (armed2)
    );

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
        pat_in = '0; cnt_clr = 1'b0; overlap = 1'b1;
`ifdef SEQDET_MASK_EN
        pat_mask_in = '0;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1; in_bit = b;
        @(posedge clk); #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_bit = 1'b1;
        do_reset();
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL reset_match got %b want 0", match);
        end
        tests++;
        if (match_count !== 8'd0) begin
            fails++; $display("FAIL reset_count got %0d want 0", match_count);
        end
        tests++;
        if (armed !== 1'b0) begin
            fails++; $display("FAIL reset_armed got %b want 0", armed);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;   // sent MSB first
        logic [6:0] e = 7'b0001001;   // expected match after each bit
        do_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            send(s[i]);
            tests++;
            if (match !== e[i]) begin
                fails++; $display("FAIL ovl_match bit%0d got %b want %b", 7 - i, match, e[i]);
            end
        end
        idle();
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL ovl_pulse_len got %b want 0", match);
        end
        tests++;
        if (match_count !== 8'd2) begin
            fails++; $display("FAIL ovl_count got %0d want 2", match_count);
        end
        tests++;
        if (armed !== 1'b1) begin
            fails++; $display("FAIL ovl_armed got %b want 1", armed);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            send(s[i]);
            tests++;
            if (match !== e[i]) begin
                fails++; $display("FAIL novl_match bit%0d got %b want %b", 7 - i, match, e[i]);
            end
            if (i == 3) begin
                tests++;
                if (armed !== 1'b0) begin
                    fails++; $display("FAIL novl_armed_after_hit got %b want 0", armed);
                end
            end
        end
        tests++;
        if (match_count !== 8'd1) begin
            fails++; $display("FAIL novl_count got %0d want 1", match_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(1'b1); send(1'b0); send(1'b1);
        do_reset();
        send(1'b1);
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL midrst_match got %b want 0", match);
        end
        tests++;
        if (armed !== 1'b0) begin
            fails++; $display("FAIL midrst_armed got %b want 0", armed);
        end
        tests++;
        if (match_count !== 8'd0) begin
            fails++; $display("FAIL midrst_count got %0d want 0", match_count);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] s = 4'b1011;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            send(s[i]);
            tests++;
            if (match !== (i == 0)) begin
                fails++; $display("FAIL gap_match bit%0d got %b want %b", 4 - i, match, i == 0);
            end
            if (i != 0) begin
                idle(); idle();
            end
        end
        for (int k = 0; k < 2; k++) begin
            idle();
            tests++;
            if (match !== 1'b0) begin
                fails++; $display("FAIL gap_once idle%0d got %b want 0", k, match);
            end
        end
        tests++;
        if (match_count !== 8'd1) begin
            fails++; $display("FAIL gap_count got %0d want 1", match_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        overlap = 1'b1;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        for (int r = 0; r < 5; r++) begin
            send(1'b0); send(1'b1); send(1'b1);
        end
        tests++;
        if (match_count2 !== 2'd3) begin
            fails++; $display("FAIL sat_count2 got %0d want 3", match_count2);
        end
        tests++;
        if (match_count !== 8'd6) begin
            fails++; $display("FAIL sat_count8 got %0d want 6", match_count);
        end
        send(1'b0); send(1'b1);
        cnt_clr = 1'b1;
        send(1'b1);
        tests++;
        if (match_count2 !== 2'd1) begin
            fails++; $display("FAIL clr_hit_count2 got %0d want 1", match_count2);
        end
        tests++;
        if (match_count !== 8'd1) begin
            fails++; $display("FAIL clr_hit_count8 got %0d want 1", match_count);
        end
        cnt_clr = 1'b1;
        idle();
        cnt_clr = 1'b0;
        tests++;
        if (match_count !== 8'd0) begin
            fails++; $display("FAIL clr_count got %0d want 0", match_count);
        end
    endtask

    task automatic test_pat_load();
        logic [3:0] s = 4'b0110;
        do_reset();
        pat_load = 1'b1; pat_in = 4'b0110;
        in_valid = 1'b1; in_bit = 1'b0;
        @(posedge clk); #1;
        pat_load = 1'b0; in_valid = 1'b0;
        tests++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL load_match got %b want 0", match);
        end
        for (int i = 3; i >= 0; i--) begin
            send(s[i]);
            if (i == 1) begin
                tests++;
                if (armed !== 1'b0) begin
                    fails++; $display("FAIL load_drop_armed got %b want 0", armed);
                end
            end
            tests++;
            if (match !== (i == 0)) begin
                fails++; $display("FAIL load_match bit%0d got %b want %b", 4 - i, match, i == 0);
            end
        end
    endtask

`ifdef SEQDET_MASK_EN
    task automatic test_mask();
        do_reset();
        pat_load = 1'b1; pat_in = 4'b1011; pat_mask_in = 4'b0100;
        idle();
        pat_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            tests++;
            if (match !== (i == 3)) begin
                fails++; $display("FAIL mask_match bit%0d got %b want %b", i + 1, match, i == 3);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_mid_reset();
        test_gaps();
        test_saturate();
        test_pat_load();
`ifdef SEQDET_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, successor to the fixed 3-bit-state sequence detector FSMs. Detects a WIDTH-bit pattern on a qualified serial bit stream. Pattern is programmable at run time; overlapping or non-overlapping detection is selected by a mode pin. Provides a registered match pulse and a saturating match counter. Sits after the serial-input sampler, feeding the status/interrupt logic.

Parameters:
WIDTH, 4, pattern length in bits (2..32)
PATTERN, 4'b1011, reset/default pattern; MSB = first bit received
CNT_W, 8, match counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  in_bit is accepted this cycle
in_bit  in  1  serial data bit
overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled each accepted bit
pat_load  in  1  load pat_in as the new pattern
pat_in  in  WIDTH  new pattern, MSB first
cnt_clr  in  1  clear match_count
match  out  1  one-cycle pulse: pattern completed by the previous accepted bit
match_count  out  CNT_W  saturating count of matches
armed  out  1  history holds at least WIDTH valid bits

Behaviour:
- Reset (rst=1 at edge): hist=0, fill=0, pat=PATTERN, match=0, match_count=0, armed=0. Reset mid-stream discards all partial history.
- History shifts left, new bit enters at LSB: hist_n = {hist[WIDTH-2:0], in_bit}.
- fill counter (0..WIDTH) saturates at WIDTH; armed = (fill == WIDTH).
- States: S_FILL (fill<WIDTH), S_ARMED (fill==WIDTH).
- Accepted bit (in_valid=1, pat_load=0): hist<=hist_n, fill<=min(fill+1,WIDTH).
- Hit = accepted bit AND fill+1>=WIDTH AND hist_n==pat.
- match registered: asserts on the edge that accepts the completing bit, visible the following cycle, high for exactly 1 cycle. No combinational path from in_bit to match.
- On hit with overlap=1: hist/fill update normally; state stays S_ARMED.
- On hit with overlap=0: fill<=0, go to S_FILL; the next match needs WIDTH fresh bits.
- in_valid=0: hist, fill and state hold; match<=0.
- pat_load=1: pat<=pat_in; fill<=0; match<=0. Priority over in_valid: the same-cycle bit is discarded and not compared. The new pattern applies from the next accepted bit.
- match_count: +1 on each hit; saturates at 2^CNT_W-1, no wrap.
  - cnt_clr=1 with no hit: count<=0.
  - cnt_clr=1 with hit in the same cycle: count<=1.
- Pattern width mismatch impossible; all compares are full WIDTH bits.

Optional Feature:
Macro SEQDET_MASK_EN.
- Defined: adds port pat_mask_in (in, WIDTH), loaded together with pat_in on pat_load; reset value all-zero. Mask bit 1 = don't-care. Hit = ((hist_n ^ pat) & ~mask)==0.
- Not defined: no mask port or register; exact compare.

Test Plan:
1. WIDTH=4, PATTERN=1011, overlap=1, stream 1,0,1,1,0,1,1 every cycle -> match pulses the cycle after bits 4 and 7; match_count=2.
2. Same stream, overlap=0 -> single match after bit 4; no match after bit 7; count=1; armed=0 the cycle after the match.
3. Stream 1,0,1, assert rst, then 1 -> no match; armed=0; count=0.
4. Stream 1,0,1,1 with in_valid low for 2 cycles between each bit -> match exactly 1 cycle after the 4th valid bit, and only once.
5. CNT_W=2, overlap=1, stream 1011 followed by 011 repeated 5 times -> count saturates at 3. Then cnt_clr together with a hit -> count=1.
6. pat_load pat_in=0110 with in_valid=1 (that bit is dropped), then stream 0,1,1,0 -> match. With SEQDET_MASK_EN, pattern 1011 and mask 0100, stream 1,1,1,1 -> match.
